// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit with a single outstanding memory request
// feeding an in-order instruction queue.
//
// Ports:
//   clk          single clock, rising-edge state updates
//   reset        asynchronous active-high reset
//   redirect     flush queue and restart fetch at redirect_pc
//   redirect_pc  new fetch address, word-aligned on capture
//   mem_req      instruction-memory read request (held until mem_ack)
//   mem_addr     address of the outstanding request
//   mem_ack      memory returns mem_rdata this cycle
//   mem_rdata    instruction word from memory
//   out_valid    queue head holds a valid instruction
//   out_instr    instruction at queue head
//   out_pc       address of out_instr
//   out_ready    consumer accepts the head this cycle
//   count        current queue occupancy
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          push, pop, issue;

    // A request is only issued while there is room for its data, so a push
    // can never land in a full queue. DROP keeps the old request on the bus
    // until memory answers, then throws the data away.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: if (!redirect && count < FULL) begin
                issue     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (mem_ack) begin
                push      = !redirect;
                state_nxt = IDLE;
            end else if (redirect) begin
                state_nxt = DROP;
            end
            DROP: if (mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign fetch_pc_nxt = redirect ? (redirect_pc & ~32'd3) : push ? fetch_pc + 32'd4 : fetch_pc;
    assign pop          = out_valid && out_ready && !redirect;
    assign mem_req      = state != IDLE;
    assign out_valid    = count != '0;
    assign out_instr    = q_instr[rd_ptr];
    assign out_pc       = q_pc[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_addr <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (issue) mem_addr <= fetch_pc;
            if (redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= (push && !pop) ? count + 1'b1 : (!push && pop) ? count - 1'b1 : count;
            end
        end
    end

    // Queue storage carries no reset; contents are ignored while out_valid=0.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= mem_rdata;
            q_pc[wr_ptr]    <= fetch_pc;
        end
    end
endmodule
